mas_alu_arbiter: RTL
====================

# mas_alu_arbiter

Round-robin arbiter that shares one `mas_alu_top` instance between `NREQ` independent requesters. Each client sees a valid/ready request channel and a valid/ready response channel. The block captures one client's command and operands, sequences the ALU request/ready handshake, and guards it with a timeout. It returns the result, plus an error flag, to the owning client. It sits between the client blocks and the ALU's `mas_alu_req` / `mas_alu_ready` port pair.

## Interface

- `NREQ`, 4, number of requesters, 2..16
- `TIMEOUT`, 64, maximum cycles to wait for `mas_alu_ready` after issue; 0 disables the timeout
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cli_req_vld`  in  NREQ  per-client request valid
- `cli_req_rdy`  out  NREQ  per-client request accept; one-hot or zero
- `cli_cmd`  in  NREQ x type_mas_alu_cmd  per-client ALU command
- `cli_op1`  in  NREQ x `MAS_BLEN  per-client operand 1, client i at bits [i*`MAS_BLEN +: `MAS_BLEN]
- `cli_op2`  in  NREQ x `MAS_BLEN  per-client operand 2, same packing
- `cli_rsp_vld`  out  NREQ  per-client response valid; one-hot or zero
- `cli_rsp_rdy`  in  NREQ  per-client response accept
- `cli_rsp_res`  out  `MAS_BLEN  result, shared bus, qualified by `cli_rsp_vld`
- `cli_rsp_err`  out  1  timeout error, qualified by `cli_rsp_vld`
- `mas_alu_req`  out  1  request to ALU
- `mas_alu_cmd`  out  type_mas_alu_cmd  command to ALU
- `mas_alu_op1`, `mas_alu_op2`  out  `MAS_BLEN  operands to ALU
- `mas_alu_ready`  in  1  ALU completion; `mas_alu_res` is valid in the same cycle
- `mas_alu_res`  in  `MAS_BLEN  ALU result
- `arb_busy`  out  1  high in any state other than IDLE

## Operation

- FSM states: IDLE, ISSUE, RESP. State, grant index, pointer, holding registers and counter are all registered.
- **IDLE**
  - If any `cli_req_vld` is set, select the winner by round-robin, searching from `last_gnt+1` upward with wrap to 0.
  - Assert `cli_req_rdy[win]` combinationally in this cycle.
  - Capture `cli_cmd[win]`, `cli_op1[win]` and `cli_op2[win]` into the holding registers, store `gnt_idx=win`, clear the timeout counter, and go to ISSUE.
  - If no `cli_req_vld` is set, stay in IDLE.
- **ISSUE**
  - `mas_alu_req=1`.
  - `mas_alu_cmd` and the operands come from the holding registers and stay stable for the whole state.
  - On `mas_alu_ready=1`: capture `mas_alu_res` into `res_q`, set `err_q=0`, go to RESP.
  - Otherwise the counter increments. If `TIMEOUT!=0` and the counter reaches `TIMEOUT-1` without ready: set `res_q=0`, `err_q=1`, go to RESP.
  - `mas_alu_ready` seen outside ISSUE is ignored.
- **RESP**
  - `cli_rsp_vld[gnt_idx]=1`, `cli_rsp_res=res_q`, `cli_rsp_err=err_q`.
  - On `cli_rsp_rdy[gnt_idx]=1`: set `last_gnt=gnt_idx`, go to IDLE.
  - `cli_rsp_rdy` of other clients is ignored.
- Only one transaction is outstanding at a time. Clients must not change their request fields while `cli_req_vld=1` and not yet accepted.
- Pointer width is `$clog2(NREQ)`. Counter width is `$clog2(TIMEOUT+1)` and saturates; it never wraps.

## Timing

- Reset values: state IDLE, `last_gnt=NREQ-1` (so client 0 wins first), `mas_alu_req=0`, `cli_req_rdy=0`, `cli_rsp_vld=0`, `cli_rsp_res=0`, `cli_rsp_err=0`, `arb_busy=0`, holding registers 0.
- Accept in cycle T gives `mas_alu_req=1` from T+1.
- ALU ready in cycle T2 gives `mas_alu_req=0` and `cli_rsp_vld=1` from T2+1.
- Response accept in cycle T3 returns to IDLE at T3+1. The earliest next accept is T3+1, so there is no back-to-back accept in the same cycle as the response.
- Minimum transaction is 3 cycles (accept, issue with ready the same cycle, response accepted immediately).
- If ALU ready arrives in the first ISSUE cycle, it is accepted. The ALU never sees `mas_alu_req` and `mas_alu_ready` for a different grant.
- Simultaneous requests from all clients: each client is served exactly once per `NREQ` transactions.
- Timeout with `TIMEOUT=N`: `mas_alu_req` is high for exactly N cycles, then drops.
- Asynchronous reset mid-transaction: all outputs return to their reset values immediately. The in-flight result is discarded and no response is issued.

## Test plan

- **Single transaction.** Client 2 requests with op1=5, op2=3 and an ADD command; the ALU model returns ready after 2 cycles with res=8. Required: `cli_req_rdy[2]` pulses for 1 cycle, `mas_alu_req` is high for 2 cycles, then `cli_rsp_vld[2]=1`, res=8, err=0.
- **Round-robin fairness.** All 4 clients hold valid continuously, with the ALU answering in 1 cycle. Required: grant order 0,1,2,3,0 and a transaction every 3 cycles.
- **Timeout.** `TIMEOUT=4` and the ALU never answers. Required: `mas_alu_req` is high for exactly 4 cycles, then `cli_rsp_vld=1` with err=1 and res=0.
- **Response backpressure.** Hold `cli_rsp_rdy[1]=0` for 5 cycles. Required: `cli_rsp_vld[1]` and res stay stable, `cli_rsp_rdy[0]` pulses are ignored, and no new grant is issued.
- **Reset mid-ISSUE.** Assert `rst_n=0` asynchronously while in ISSUE. Required: `mas_alu_req` drops the same cycle, and after reset client 0 wins first.
- **Late or stray ready.** Pulse `mas_alu_ready` while in IDLE. Required: no response and no state change.

Source files
------------

// File: rtl/mas_alu_arbiter_if.sv
// Client request/response channels and the shared ALU port pair of mas_alu_arbiter.
// Operand and command buses pack client i at bits [i*W +: W].
`ifndef MAS_BLEN
`define MAS_BLEN 16
`endif
`ifndef MAS_CMDW
`define MAS_CMDW 4
`endif

interface mas_alu_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]             cli_req_vld;
    logic [NREQ-1:0]             cli_req_rdy;
    logic [NREQ*`MAS_CMDW-1:0]   cli_cmd;
    logic [NREQ*`MAS_BLEN-1:0]   cli_op1;
    logic [NREQ*`MAS_BLEN-1:0]   cli_op2;
    logic [NREQ-1:0]             cli_rsp_vld;
    logic [NREQ-1:0]             cli_rsp_rdy;
    logic [`MAS_BLEN-1:0]        cli_rsp_res;
    logic                        cli_rsp_err;
    logic                        mas_alu_req;
    logic [`MAS_CMDW-1:0]        mas_alu_cmd;
    logic [`MAS_BLEN-1:0]        mas_alu_op1;
    logic [`MAS_BLEN-1:0]        mas_alu_op2;
    logic                        mas_alu_ready;
    logic [`MAS_BLEN-1:0]        mas_alu_res;
    logic                        arb_busy;

    modport slave (
        input  cli_req_vld, cli_cmd, cli_op1, cli_op2, cli_rsp_rdy,
        input  mas_alu_ready, mas_alu_res,
        output cli_req_rdy, cli_rsp_vld, cli_rsp_res, cli_rsp_err,
        output mas_alu_req, mas_alu_cmd, mas_alu_op1, mas_alu_op2, arb_busy
    );

    modport master (
        output cli_req_vld, cli_cmd, cli_op1, cli_op2, cli_rsp_rdy,
        output mas_alu_ready, mas_alu_res,
        input  cli_req_rdy, cli_rsp_vld, cli_rsp_res, cli_rsp_err,
        input  mas_alu_req, mas_alu_cmd, mas_alu_op1, mas_alu_op2, arb_busy
    );
endinterface

// File: rtl/mas_alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ clients, one transaction at a time,
// with a saturating timeout on the ALU ready handshake.
`ifndef MAS_BLEN
`define MAS_BLEN 16
`endif
`ifndef MAS_CMDW
`define MAS_CMDW 4
`endif

module mas_alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    mas_alu_arbiter_if.slave bus
);
    localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int BL        = `MAS_BLEN;
    localparam int CMW       = `MAS_CMDW;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0]   TO_LAST = CW'(TO_LAST_I);
    localparam logic [NREQ-1:0] LSB_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   last_gnt_r;
    logic [PW-1:0]   gnt_idx_r;
    logic [CMW-1:0]  cmd_hold_r;
    logic [BL-1:0]   op1_hold_r;
    logic [BL-1:0]   op2_hold_r;
    logic [BL-1:0]   res_r;
    logic            err_r;
    logic [CW-1:0]   cnt_r;
    logic            alu_req_r;
    logic [NREQ-1:0] rsp_vld_r;
    logic            busy_r;

    logic [PW-1:0]   win_s;
    logic [PW-1:0]   idx_s;
    logic            any_s;

    // Round-robin winner: first valid client after last_gnt, wrapping to 0
    always_comb begin
        win_s = last_gnt_r;
        idx_s = last_gnt_r;
        any_s = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = PW'((int'(last_gnt_r) + k) % NREQ);
            win_s = (!any_s && bus.cli_req_vld[idx_s]) ? idx_s : win_s;
            any_s = any_s | bus.cli_req_vld[idx_s];
        end
    end

    // Accept is the only combinational output so a client is taken in the cycle it wins
    assign bus.cli_req_rdy = (state_r == ST_IDLE && any_s) ? (LSB_ONE << win_s) : '0;
    assign bus.mas_alu_req = alu_req_r;
    assign bus.mas_alu_cmd = cmd_hold_r;
    assign bus.mas_alu_op1 = op1_hold_r;
    assign bus.mas_alu_op2 = op2_hold_r;
    assign bus.cli_rsp_vld = rsp_vld_r;
    assign bus.cli_rsp_res = res_r;
    assign bus.cli_rsp_err = err_r;
    assign bus.arb_busy    = busy_r;

    // Transaction FSM with grant bookkeeping, holding registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            last_gnt_r <= PW'(NREQ - 1);
            gnt_idx_r  <= '0;
            cmd_hold_r <= '0;
            op1_hold_r <= '0;
            op2_hold_r <= '0;
            res_r      <= '0;
            err_r      <= 1'b0;
            cnt_r      <= '0;
            alu_req_r  <= 1'b0;
            rsp_vld_r  <= '0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        state_r    <= ST_ISSUE;
                        gnt_idx_r  <= win_s;
                        cmd_hold_r <= bus.cli_cmd[win_s*CMW +: CMW];
                        op1_hold_r <= bus.cli_op1[win_s*BL +: BL];
                        op2_hold_r <= bus.cli_op2[win_s*BL +: BL];
                        cnt_r      <= '0;
                        alu_req_r  <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.mas_alu_ready) begin
                        res_r     <= bus.mas_alu_res;
                        err_r     <= 1'b0;
                        alu_req_r <= 1'b0;
                        rsp_vld_r <= LSB_ONE << gnt_idx_r;
                        state_r   <= ST_RESP;
                    end else if ((TIMEOUT != 0) && (cnt_r == TO_LAST)) begin
                        res_r     <= '0;
                        err_r     <= 1'b1;
                        alu_req_r <= 1'b0;
                        rsp_vld_r <= LSB_ONE << gnt_idx_r;
                        state_r   <= ST_RESP;
                    end else if (cnt_r != '1) begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_RESP: begin
                    // Only the owning client's accept ends the transaction
                    if (bus.cli_rsp_rdy[gnt_idx_r]) begin
                        state_r    <= ST_IDLE;
                        last_gnt_r <= gnt_idx_r;
                        rsp_vld_r  <= '0;
                        busy_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    alu_req_r <= 1'b0;
                    rsp_vld_r <= '0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end
endmodule
